rate_detector: RTL

RATE_DETECTOR -- requirements
Module: rate_detector

---
 rtl/rate_detector.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rate_detector.sv
// rate_detector: measures the spacing of rising edges on an asynchronous
// divided-clock input, classifies it as one of four nominal periods
// (32/16/8/4 CLK cycles) and reports lock after two agreeing measurements.
module rate_detector #(
    parameter int TOL     = 1,   // allowed deviation from a nominal period
    parameter int TIMEOUT = 63   // edge-less cycles that abandon a measurement (40..63)
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       enable,
    input  logic       in_sig,
    output logic [1:0] frecuency,
    output logic       valid,
    output logic       locked,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_LOCK    = 2'd3
    } state_t;

    localparam logic [6:0] TOL_7     = 7'(TOL);
    localparam logic [5:0] TIMEOUT_6 = 6'(TIMEOUT);
    localparam logic [5:0] CNT_MAX   = 6'd63;

    state_t     r_state, w_state_nxt;
    logic       r_sync1, r_sync2, r_hist;
    logic       w_edge;
    logic [5:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_freq, w_freq_nxt;
    logic [1:0] r_cand, w_cand_nxt;
    logic       r_cand_vld, w_cand_vld_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic       w_match;
    logic [1:0] w_code;
    logic       w_to_hit;

    // |p - nom| <= TOL, evaluated unsigned at 7 bits so neither side wraps
    function automatic logic near(input logic [5:0] p, input logic [6:0] nom);
        logic [6:0] p7;
        logic [6:0] diff;
        p7   = {1'b0, p};
        diff = (p7 >= nom) ? (p7 - nom) : (nom - p7);
        return diff <= TOL_7;
    endfunction

    // Two-flop synchronizer plus history flop for rising-edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours, as real hardware does.
            r_sync1 <= in_sig;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_edge   = r_sync2 & ~r_hist;
    assign w_to_hit = (r_cnt == TIMEOUT_6) && !w_edge;

    // Classify the current counter value as a measured period
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_match = 1'b1;
        w_code  = 2'b00;
        if (near(r_cnt, 7'd32)) begin
            w_code = 2'b00;
        end else if (near(r_cnt, 7'd16)) begin
            w_code = 2'b01;
        end else if (near(r_cnt, 7'd8)) begin
            w_code = 2'b10;
        end else if (near(r_cnt, 7'd4)) begin
            w_code = 2'b11;
        end else begin
            w_match = 1'b0;
        end
    end

    // Next-state, counter, candidate and output-pulse logic
    always_comb begin
        w_state_nxt    = r_state;
        w_freq_nxt     = r_freq;
        w_cand_nxt     = r_cand;
        w_cand_vld_nxt = r_cand_vld;
        w_valid_nxt    = 1'b0;
        w_timeout_nxt  = 1'b0;
        w_cnt_nxt      = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 6'd1;

        if (!enable) begin
            w_state_nxt    = S_IDLE;
            w_cand_nxt     = 2'b00;
            w_cand_vld_nxt = 1'b0;
            w_cnt_nxt      = 6'd0;
        end else if (r_state == S_IDLE) begin
            w_cnt_nxt   = 6'd0;
            w_state_nxt = S_ARM;
        end else if (w_edge) begin
            // Every edge restarts the period count; what it means depends on state
            w_cnt_nxt = 6'd1;
            case (r_state)
                S_ARM: begin
                    w_state_nxt = S_MEASURE;
                end
                S_MEASURE: begin
                    if (w_match) begin
                        w_valid_nxt = 1'b1;
                        w_freq_nxt  = w_code;
                        if (r_cand_vld && (r_cand == w_code)) begin
                            w_state_nxt = S_LOCK;
                        end else begin
                            w_cand_nxt     = w_code;
                            w_cand_vld_nxt = 1'b1;
                        end
                    end else begin
                        w_cand_vld_nxt = 1'b0;
                    end
                end
                S_LOCK: begin
                    if (w_match && (w_code == r_freq)) begin
                        w_valid_nxt = 1'b1;
                    end else if (w_match) begin
                        w_valid_nxt    = 1'b1;
                        w_freq_nxt     = w_code;
                        w_cand_nxt     = w_code;
                        w_cand_vld_nxt = 1'b1;
                        w_state_nxt    = S_MEASURE;
                    end else begin
                        w_cand_vld_nxt = 1'b0;
                        w_state_nxt    = S_MEASURE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if (w_to_hit) begin
            // No edge for TIMEOUT cycles: abandon the measurement, keep frecuency
            w_timeout_nxt  = 1'b1;
            w_cand_nxt     = 2'b00;
            w_cand_vld_nxt = 1'b0;
            w_cnt_nxt      = 6'd0;
            w_state_nxt    = S_ARM;
        end
    end

    // State, counter, candidate and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_freq     <= 2'b00;
            r_cand     <= 2'b00;
            r_cand_vld <= 1'b0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_freq     <= w_freq_nxt;
            r_cand     <= w_cand_nxt;
            r_cand_vld <= w_cand_vld_nxt;
            r_valid    <= w_valid_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign frecuency = r_freq;
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    assign locked    = (r_state == S_LOCK);

endmodule
